pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and return-address sequencer driven by the decode-stage control unit. It consumes the PC-source select, PC-write strobe and push/pop controls and produces the fetch address each instruction. It holds a hardware return-address stack for CALL/RET, and latches halt and stack-fault conditions. It sits between decode (control inputs), the ALU (branch condition) and instruction fetch (address output).

## Interface
- `PC_WIDTH`, 16, width of PC and all target addresses
- `STACK_DEPTH`, 8, return-stack entries (power of two, ≥2)
- `RESET_PC`, 0, PC value after reset
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `pc_src` in 3: next-PC select; 000 RET, 001 TARGET, 010 SEQ, 011 JUMP, 100 HALT, 101–111 reserved
- `pc_write` in 1: one-cycle strobe that commits next PC (once per instruction)
- `push` in 1: current instruction is a CALL (level, valid whole instruction)
- `pop` in 1: current instruction is a RET (level)
- `push_pop_en` in 1: one-cycle strobe enabling the stack operation, always at least one cycle before `pc_write`
- `take_branch` in 1: ALU condition result, valid when `pc_write` is high
- `branch_target` in PC_WIDTH: target for TARGET
- `jump_target` in PC_WIDTH: target for JUMP
- `pc` out PC_WIDTH: current fetch address
- `halted` out 1: high in HALTED or FAULT
- `fault` out 1: high in FAULT
- `overflow` out 1: sticky, push attempted when full
- `underflow` out 1: sticky, pop attempted when empty
- `depth` out clog2(STACK_DEPTH)+1: entries in use

## Operation
- States: RUN, HALTED, FAULT. Reset → RUN.
- Stack op fires only on `push_pop_en` in RUN:
  - `push` only: write `pc+1` (mod 2^PC_WIDTH) at `stack[depth]`, then `depth+1`.
  - `pop` only: `ret_addr <= stack[depth-1]`, then `depth-1`.
  - Both high: no stack change, no flag.
- Push with `depth==STACK_DEPTH`: no write, `overflow<=1`, → FAULT.
- Pop with `depth==0`: `ret_addr` unchanged, `underflow<=1`, → FAULT.
- PC update fires only on `pc_write` in RUN:
  - RET: `pc<=ret_addr`.
  - TARGET: if `push` or `take_branch`, `pc<=branch_target`; otherwise `pc<=pc+1`.
  - SEQ and reserved values: `pc<=pc+1`, wrapping modulo 2^PC_WIDTH.
  - JUMP: `pc<=jump_target`.
  - HALT: pc unchanged, → HALTED.
- HALTED and FAULT are exit-only-by-reset. In these states `pc`, `depth` and the stack are frozen, and all strobes are ignored.
- If a fault-causing `push_pop_en` and a `pc_write` occur in the same cycle, the fault wins and pc is not updated.

## Timing
- Reset values:
  - `pc=RESET_PC`
  - `depth=0`
  - `ret_addr=0`
  - `halted=0`, `fault=0`, `overflow=0`, `underflow=0`
  - stack contents don't-care
- `pc` is visible one cycle after the `pc_write` edge. All outputs are registered.
- Stack write/read completes at the `push_pop_en` edge, so `ret_addr` is valid for any later `pc_write` of the same instruction.
- `halted`/`fault` assert in the cycle after the triggering edge.
- Reset in any state, including mid-instruction between `push_pop_en` and `pc_write`, restores reset values on the next edge. A pending op is discarded.

## Structure
- Shared package holds:
  - `pc_src` encodings `PC_SRC_RET/TARGET/SEQ/JUMP/HALT`
  - state encodings `ST_RUN/ST_HALTED/ST_FAULT`
- Sub-module `return_stack`: LIFO storing PC_WIDTH-bit entries. It has push/pop/data-in/data-out/depth/full/empty ports. It has no fault policy; `pc_sequencer` owns the flags and the FSM.

## Test plan
- Reset, then 3 instructions with SEQ → `pc` = 0,1,2,3. With `pc=16'hFFFF`, SEQ → `pc=0`.
- CALL at pc=5 (push, TARGET, `branch_target=40`): `pc=40`, `depth=1`. RET: `pc=6`, `depth=0`.
- TARGET with `take_branch=0` at pc=10 → 11. With `take_branch=1`, `branch_target=3` → 3. JUMP with `jump_target=200` → 200.
- 8 nested CALLs: `depth=8`. 9th push → `overflow=1`, `fault=1`, `halted=1`, pc frozen. Further strobes have no effect. Reset clears all flags.
- RET with `depth=0` → `underflow=1`, FAULT, pc unchanged.
- HALT at pc=7 → `halted=1`, `fault=0`, pc stays 7 under further `pc_write`. Reset asserted between `push_pop_en` and `pc_write` of a CALL → `pc=RESET_PC`, `depth=0`.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer: next-PC selects and FSM states.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    PC_SRC_RET    = 3'b000,
    PC_SRC_TARGET = 3'b001,
    PC_SRC_SEQ    = 3'b010,
    PC_SRC_JUMP   = 3'b011,
    PC_SRC_HALT   = 3'b100
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_FAULT  = 2'b11
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode-to-sequencer control bundle plus the sequencer's fetch address and status outputs.
interface pc_sequencer_if #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned STACK_DEPTH = 8
);
  localparam int unsigned DepthW = $clog2(STACK_DEPTH) + 1;

  logic [2:0]          pc_src;
  logic                pc_write;
  logic                push;
  logic                pop;
  logic                push_pop_en;
  logic                take_branch;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pc;
  logic                halted;
  logic                fault;
  logic                overflow;
  logic                underflow;
  logic [DepthW-1:0]   depth;

  modport master (
    output pc_src, pc_write, push, pop, push_pop_en, take_branch, branch_target, jump_target,
    input  pc, halted, fault, overflow, underflow, depth
  );

  modport slave (
    input  pc_src, pc_write, push, pop, push_pop_en, take_branch, branch_target, jump_target,
    output pc, halted, fault, overflow, underflow, depth
  );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// LIFO of return addresses. Guards itself against push-when-full and pop-when-empty,
// but leaves any fault policy to the instantiating sequencer.
module return_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AddrW  = $clog2(DEPTH),
  localparam int unsigned DepthW = AddrW + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WIDTH-1:0]  i_data,
  output logic [WIDTH-1:0]  o_data,
  output logic [DepthW-1:0] o_depth,
  output logic              o_full,
  output logic              o_empty
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DepthW-1:0] r_depth;
  logic [AddrW-1:0]  w_rd_idx;

  assign o_full   = (r_depth == DepthW'(DEPTH));
  assign o_empty  = (r_depth == '0);
  assign o_depth  = r_depth;
  assign w_rd_idx = AddrW'(r_depth - DepthW'(1));
  // Top-of-stack is read combinationally so the caller can latch it on the pop edge.
  assign o_data   = r_mem[w_rd_idx];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_depth <= '0;
    end else if (i_push && !o_full) begin
      r_depth <= r_depth + DepthW'(1);
    end else if (i_pop && !o_empty) begin
      r_depth <= r_depth - DepthW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && i_push && !o_full) begin
      r_mem[r_depth[AddrW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects and commits the next fetch address, drives the
// return-address stack for CALL/RET, and latches halt and stack-fault conditions.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         STACK_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input logic           i_clk,
  input logic           i_reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned DepthW = $clog2(STACK_DEPTH) + 1;

  state_e              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, r_ret_addr, w_pc_nxt, w_pc_inc, w_stk_rd;
  logic                r_overflow, r_underflow;
  logic [DepthW-1:0]   w_depth;
  logic                w_full, w_empty, w_run, w_do_push, w_do_pop;
  logic                w_ovf, w_unf, w_fault_evt, w_pc_upd;

  assign w_run       = (r_state == ST_RUN);
  assign w_do_push   = w_run && bus.push_pop_en && bus.push && !bus.pop;
  assign w_do_pop    = w_run && bus.push_pop_en && bus.pop && !bus.push;
  assign w_ovf       = w_do_push && w_full;
  assign w_unf       = w_do_pop && w_empty;
  assign w_fault_evt = w_ovf || w_unf;
  // A fault raised in the same cycle as pc_write suppresses the PC commit.
  assign w_pc_upd    = w_run && bus.pc_write && !w_fault_evt;
  assign w_pc_inc    = r_pc + PC_WIDTH'(1);

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_do_push),
    .i_pop   (w_do_pop),
    .i_data  (w_pc_inc),
    .o_data  (w_stk_rd),
    .o_depth (w_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_run) begin
      if (w_fault_evt) begin
        w_state_nxt = ST_FAULT;
      end else if (bus.pc_write && bus.pc_src == PC_SRC_HALT) begin
        w_state_nxt = ST_HALTED;
      end
    end
  end

  always_comb begin
    bus.halted    = (r_state != ST_RUN);
    bus.fault     = (r_state == ST_FAULT);
    bus.pc        = r_pc;
    bus.depth     = w_depth;
    bus.overflow  = r_overflow;
    bus.underflow = r_underflow;
  end

  always_comb begin
    w_pc_nxt = w_pc_inc;
    case (bus.pc_src)
      PC_SRC_RET:    w_pc_nxt = r_ret_addr;
      PC_SRC_TARGET: w_pc_nxt = (bus.push || bus.take_branch) ? bus.branch_target : w_pc_inc;
      PC_SRC_JUMP:   w_pc_nxt = bus.jump_target;
      PC_SRC_HALT:   w_pc_nxt = r_pc;
      default:       w_pc_nxt = w_pc_inc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc        <= RESET_PC;
      r_ret_addr  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pc_upd) begin
        r_pc <= w_pc_nxt;
      end
      if (w_do_pop && !w_empty) begin
        r_ret_addr <= w_stk_rd;
      end
      r_overflow  <= r_overflow || w_ovf;
      r_underflow <= r_underflow || w_unf;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PC, depth and flag values.
module tb_pc_sequencer;

  localparam logic [2:0] SrcRet    = 3'b000;
  localparam logic [2:0] SrcTarget = 3'b001;
  localparam logic [2:0] SrcSeq    = 3'b010;
  localparam logic [2:0] SrcJump   = 3'b011;
  localparam logic [2:0] SrcHalt   = 3'b100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pc_sequencer_if #(.PC_WIDTH(16), .STACK_DEPTH(8)) bus ();

  pc_sequencer #(
    .PC_WIDTH    (16),
    .STACK_DEPTH (8),
    .RESET_PC    (16'h0000)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic instr(input logic [2:0] src, input logic psh, input logic pp,
                       input logic tbr, input logic [15:0] bt, input logic [15:0] jt);
    bus.push          = psh;
    bus.pop           = pp;
    bus.pc_src        = src;
    bus.take_branch   = tbr;
    bus.branch_target = bt;
    bus.jump_target   = jt;
    if (psh || pp) begin
      bus.push_pop_en = 1'b1;
      step();
      bus.push_pop_en = 1'b0;
    end
    bus.pc_write = 1'b1;
    step();
    bus.pc_write = 1'b0;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic h, input logic f,
                             input logic ov, input logic un);
    check({tag, "_halted"}, 32'(bus.halted), 32'(h));
    check({tag, "_fault"}, 32'(bus.fault), 32'(f));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(ov));
    check({tag, "_unf"}, 32'(bus.underflow), 32'(un));
  endtask

  initial begin
    bus.pc_src = SrcSeq;
    bus.pc_write = 1'b0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.push_pop_en = 1'b0;
    bus.take_branch = 1'b0;
    bus.branch_target = '0;
    bus.jump_target = '0;
    step();
    do_reset();

    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_depth", 32'(bus.depth), 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 3; i++) begin
      instr(SrcSeq, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      check("seq_pc", 32'(bus.pc), 32'(i));
    end

    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFF);
    check("jump_ffff", 32'(bus.pc), 32'hFFFF);
    instr(SrcSeq, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("seq_wrap", 32'(bus.pc), 32'h0);

    // CALL / RET pair
    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'd5);
    instr(SrcTarget, 1'b1, 1'b0, 1'b0, 16'd40, 16'h0);
    check("call_pc", 32'(bus.pc), 32'd40);
    check("call_depth", 32'(bus.depth), 32'd1);
    instr(SrcRet, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    check("ret_pc", 32'(bus.pc), 32'd6);
    check("ret_depth", 32'(bus.depth), 32'd0);

    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'd10);
    instr(SrcTarget, 1'b0, 1'b0, 1'b0, 16'd3, 16'h0);
    check("br_not_taken", 32'(bus.pc), 32'd11);
    instr(SrcTarget, 1'b0, 1'b0, 1'b1, 16'd3, 16'h0);
    check("br_taken", 32'(bus.pc), 32'd3);
    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'd200);
    check("jump_200", 32'(bus.pc), 32'd200);
    instr(3'b110, 1'b0, 1'b0, 1'b1, 16'd9, 16'd9);
    check("reserved_seq", 32'(bus.pc), 32'd201);

    // Nested calls: call i sits at pc 20+10i and targets 30+10i, pushing 21+10i
    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'd20);
    for (int i = 0; i < 8; i++) begin
      instr(SrcTarget, 1'b1, 1'b0, 1'b0, 16'(30 + 10 * i), 16'h0);
    end
    check("nest_pc", 32'(bus.pc), 32'd100);
    check("nest_depth", 32'(bus.depth), 32'd8);
    instr(SrcRet, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    check("nest_ret_pc", 32'(bus.pc), 32'd91);
    check("nest_ret_depth", 32'(bus.depth), 32'd7);
    instr(SrcTarget, 1'b1, 1'b0, 1'b0, 16'd100, 16'h0);
    check("refill_depth", 32'(bus.depth), 32'd8);
    check("refill_pc", 32'(bus.pc), 32'd100);

    // Ninth push with pc_write in the same cycle: the fault wins
    bus.push = 1'b1;
    bus.push_pop_en = 1'b1;
    bus.pc_write = 1'b1;
    bus.pc_src = SrcJump;
    bus.jump_target = 16'd500;
    step();
    bus.push = 1'b0;
    bus.push_pop_en = 1'b0;
    bus.pc_write = 1'b0;
    check_flags("ovf", 1'b1, 1'b1, 1'b1, 1'b0);
    check("ovf_pc", 32'(bus.pc), 32'd100);
    check("ovf_depth", 32'(bus.depth), 32'd8);

    instr(SrcRet, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'd77);
    check("fault_frz_pc", 32'(bus.pc), 32'd100);
    check("fault_frz_depth", 32'(bus.depth), 32'd8);
    check("fault_frz_unf", 32'(bus.underflow), 32'd0);

    do_reset();
    check_flags("rst2", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst2_depth", 32'(bus.depth), 32'd0);
    check("rst2_pc", 32'(bus.pc), 32'd0);

    // Underflow
    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'd33);
    instr(SrcRet, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    check_flags("unf", 1'b1, 1'b1, 1'b0, 1'b1);
    check("unf_pc", 32'(bus.pc), 32'd33);
    check("unf_depth", 32'(bus.depth), 32'd0);

    // HALT
    do_reset();
    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'd7);
    instr(SrcHalt, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_flags("halt", 1'b1, 1'b0, 1'b0, 1'b0);
    check("halt_pc", 32'(bus.pc), 32'd7);
    instr(SrcSeq, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'd1);
    check("halt_frz_pc", 32'(bus.pc), 32'd7);

    // Reset between push_pop_en and pc_write of a CALL
    do_reset();
    instr(SrcJump, 1'b0, 1'b0, 1'b0, 16'h0, 16'd9);
    bus.push = 1'b1;
    bus.pc_src = SrcTarget;
    bus.branch_target = 16'd50;
    bus.push_pop_en = 1'b1;
    step();
    bus.push_pop_en = 1'b0;
    check("mid_depth", 32'(bus.depth), 32'd1);
    reset = 1'b1;
    bus.pc_write = 1'b1;
    step();
    reset = 1'b0;
    bus.pc_write = 1'b0;
    bus.push = 1'b0;
    check("mid_rst_pc", 32'(bus.pc), 32'd0);
    check("mid_rst_depth", 32'(bus.depth), 32'd0);
    check("mid_rst_halted", 32'(bus.halted), 32'd0);
    instr(SrcSeq, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("post_rst_seq", 32'(bus.pc), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
